// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXR     = 4'd6,
    S_EXI     = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic is_mem, is_r, is_i, is_br, is_store;
  logic retire;

  assign is_store = (Opcode == OP_STORE);
  assign is_mem   = (Opcode == OP_LOAD) || is_store;
  assign is_r     = (Opcode == OP_R);
  assign is_i     = (Opcode == OP_I);
  assign is_br    = (Opcode == OP_BR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:   if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  state_d = S_MEMADDR;
          is_r:    state_d = S_EXR;
          is_i:    state_d = S_EXI;
          is_br:   state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // IR is frozen here, so re-reading Opcode is safe
      S_MEMADDR: state_d = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (MemReady) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXR:     state_d = S_ALUWB;
      S_EXI:     state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State      = state_q;
  assign Illegal    = illegal_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: vector table plus
// reset-abort and counter-wrap sequences.
module tb_multicycle_main_control;

  logic       clk;
  logic       reset;
  logic [6:0] Opcode;
  logic       MemReady;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  State;
  logic        Illegal;
  logic [31:0] InstrCount;

  logic       d4_pcw, d4_pcwc, d4_iord, d4_mr, d4_mw;
  logic       d4_irw, d4_m2r, d4_rw, d4_sa, d4_pcs;
  logic [1:0] d4_sb, d4_op;
  logic [3:0] d4_state;
  logic       d4_ill;
  logic [3:0] d4_cnt;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .Illegal(Illegal), .InstrCount(InstrCount)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(d4_pcw), .PCWriteCond(d4_pcwc), .IorD(d4_iord),
    .MemRead(d4_mr), .MemWrite(d4_mw), .IRWrite(d4_irw),
    .MemtoReg(d4_m2r), .RegWrite(d4_rw), .ALUSrcA(d4_sa),
    .ALUSrcB(d4_sb), .ALUOp(d4_op), .PCSource(d4_pcs),
    .State(d4_state), .Illegal(d4_ill), .InstrCount(d4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                 IRWrite, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                 ALUOp, PCSource};

  // {PCW,PCWC,IorD,MRd,MWr,IRW,M2R,RW,SrcA,SrcB,ALUOp,PCSrc}
  localparam logic [13:0] C_FR = 14'b1_0_0_1_0_1_0_0_0_01_00_0;
  localparam logic [13:0] C_FW = 14'b0_0_0_1_0_0_0_0_0_01_00_0;
  localparam logic [13:0] C_DE = 14'b0_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [13:0] C_MA = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [13:0] C_MR = 14'b0_0_1_1_0_0_0_0_0_00_00_0;
  localparam logic [13:0] C_MB = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [13:0] C_MW = 14'b0_0_1_0_1_0_0_0_0_00_00_0;
  localparam logic [13:0] C_ER = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [13:0] C_EI = 14'b0_0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [13:0] C_AW = 14'b0_0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [13:0] C_BR = 14'b0_1_0_0_0_0_0_0_1_00_01_1;

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] L = 7'b0000011;
  localparam logic [6:0] S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] X = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vt [30];

  initial begin
    vt = '{
      '{1'b0, R, 1'b1, 4'd0, C_FR, 1'b0, 32'd0},
      '{1'b0, R, 1'b1, 4'd0, C_FR, 1'b0, 32'd0},
      '{1'b1, R, 1'b1, 4'd0, C_FR, 1'b0, 32'd0},
      '{1'b1, R, 1'b1, 4'd1, C_DE, 1'b0, 32'd0},
      '{1'b1, R, 1'b1, 4'd6, C_ER, 1'b0, 32'd0},
      '{1'b1, R, 1'b1, 4'd8, C_AW, 1'b0, 32'd0},
      '{1'b1, L, 1'b1, 4'd0, C_FR, 1'b0, 32'd1},
      '{1'b1, L, 1'b1, 4'd1, C_DE, 1'b0, 32'd1},
      '{1'b1, L, 1'b0, 4'd2, C_MA, 1'b0, 32'd1},
      '{1'b1, L, 1'b0, 4'd3, C_MR, 1'b0, 32'd1},
      '{1'b1, L, 1'b0, 4'd3, C_MR, 1'b0, 32'd1},
      '{1'b1, L, 1'b0, 4'd3, C_MR, 1'b0, 32'd1},
      '{1'b1, L, 1'b1, 4'd3, C_MR, 1'b0, 32'd1},
      '{1'b1, L, 1'b1, 4'd4, C_MB, 1'b0, 32'd1},
      '{1'b1, B, 1'b1, 4'd0, C_FR, 1'b0, 32'd2},
      '{1'b1, B, 1'b1, 4'd1, C_DE, 1'b0, 32'd2},
      '{1'b1, B, 1'b1, 4'd9, C_BR, 1'b0, 32'd2},
      '{1'b1, X, 1'b1, 4'd0, C_FR, 1'b0, 32'd3},
      '{1'b1, X, 1'b1, 4'd1, C_DE, 1'b0, 32'd3},
      '{1'b1, X, 1'b0, 4'd0, C_FW, 1'b1, 32'd3},
      '{1'b1, I, 1'b1, 4'd0, C_FR, 1'b0, 32'd3},
      '{1'b1, I, 1'b1, 4'd1, C_DE, 1'b0, 32'd3},
      '{1'b1, I, 1'b1, 4'd7, C_EI, 1'b0, 32'd3},
      '{1'b1, I, 1'b1, 4'd8, C_AW, 1'b0, 32'd3},
      '{1'b1, S, 1'b1, 4'd0, C_FR, 1'b0, 32'd4},
      '{1'b1, S, 1'b1, 4'd1, C_DE, 1'b0, 32'd4},
      '{1'b1, S, 1'b1, 4'd2, C_MA, 1'b0, 32'd4},
      '{1'b1, S, 1'b0, 4'd5, C_MW, 1'b0, 32'd4},
      '{1'b1, S, 1'b1, 4'd5, C_MW, 1'b0, 32'd4},
      '{1'b1, S, 1'b1, 4'd0, C_FR, 1'b0, 32'd5}
    };

    reset    = 1'b0;
    Opcode   = R;
    MemReady = 1'b1;
    step(1);

    foreach (vt[i]) begin
      reset    = vt[i].rst;
      Opcode   = vt[i].op;
      MemReady = vt[i].mr;
      #1;
      chk($sformatf("v%0d_state", i), 32'(State), 32'(vt[i].st));
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl), 32'(vt[i].ctl));
      chk($sformatf("v%0d_illegal", i), 32'(Illegal), 32'(vt[i].ill));
      chk($sformatf("v%0d_count", i), InstrCount, vt[i].cnt);
      chk($sformatf("v%0d_rdwr_excl", i),
          32'(MemRead & MemWrite), 32'd0);
      step(1);
    end

    // store aborted by reset while waiting in MEMWR
    Opcode = S;
    step(2);
    MemReady = 1'b0;
    #1;
    chk("abort_pre_state", 32'(State), 32'd5);
    chk("abort_pre_memwrite", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    step(1);
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_count", InstrCount, 32'd0);
    chk("abort_count4", 32'(d4_cnt), 32'd0);
    chk("abort_memread", 32'(MemRead), 32'd1);

    // 16 R-types wrap the 4-bit counter
    reset    = 1'b1;
    MemReady = 1'b1;
    Opcode   = R;
    for (int n = 0; n < 15; n++) step(4);
    chk("wrap_pre_count4", 32'(d4_cnt), 32'd15);
    step(4);
    chk("wrap_count4", 32'(d4_cnt), 32'd0);
    chk("wrap_count32", InstrCount, 32'd16);
    chk("wrap_state", 32'(State), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
